// File: rtl/uart_frame_pkg.sv
// Shared types for the UART frame parser: FSM state and error code encodings.
package uart_frame_pkg;

    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

    localparam logic [2:0] ST_HUNT    = 3'd0;
    localparam logic [2:0] ST_LEN     = 3'd1;
    localparam logic [2:0] ST_PAYLOAD = 3'd2;
    localparam logic [2:0] ST_CSUM    = 3'd3;
    localparam logic [2:0] ST_EMIT    = 3'd4;

    typedef enum logic [2:0] {
        HUNT    = ST_HUNT,
        LEN     = ST_LEN,
        PAYLOAD = ST_PAYLOAD,
        CSUM    = ST_CSUM,
        EMIT    = ST_EMIT
    } frameState_t;

    typedef enum logic [1:0] {
        ERR_CSUM    = 2'd0,
        ERR_BADLEN  = 2'd1,
        ERR_TIMEOUT = 2'd2,
        ERR_OVERRUN = 2'd3
    } errCode_t;

endpackage

// File: rtl/uart_frame_timer.sv
// Inter-byte timeout counter; only built when UART_FRAME_TIMEOUT_EN is defined.
module uart_frame_timer #(
    parameter int TIMEOUT_CYCLES = 17360
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear || !enable) begin
            count <= '0;
        end else if (!expired) begin
            count <= count + CW'(1);
        end
    end

    // Fires on the cycle the count reaches TIMEOUT_CYCLES-1 so the registered error lands exactly TIMEOUT_CYCLES after the last byte.
    assign expired = enable && (count == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/uart_frame_parser.sv
// Sync/length/checksum frame parser behind a UART receiver; releases only verified payloads.
// Optional inter-byte timeout enabled by defining UART_FRAME_TIMEOUT_EN.
module uart_frame_parser
    import uart_frame_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE      = DEFAULT_SYNC_BYTE,
    parameter int         MAX_LEN        = 16,
    parameter int         TIMEOUT_CYCLES = 17360
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rxData,
    input  logic       rxValid,
    output logic [7:0] outData,
    output logic       outValid,
    input  logic       outReady,
    output logic       outLast,
    output logic       frameOk,
    output logic       frameErr,
    output logic [1:0] errCode,
    output logic       busy
);

    localparam int IW = $clog2(MAX_LEN + 1);
    localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [IW-1:0] ONE = IW'(1);

    if (MAX_LEN < 1 || MAX_LEN > 255 || TIMEOUT_CYCLES < 1) begin : gBadParam
        $error("uart_frame_parser: parameter out of range");
    end

    frameState_t   state, stateNext;
    errCode_t      errNext;
    logic          errPulse, okPulse, timeoutHit;
    logic [IW-1:0] len, idx, rdIdx, rdNext;
    logic [7:0]    sum;
    logic [7:0]    payloadBuf [MAX_LEN];

`ifdef UART_FRAME_TIMEOUT_EN
    uart_frame_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) uTimer (
        .clk     (clk),
        .reset   (reset),
        .clear   (rxValid),
        .enable  (state == LEN || state == PAYLOAD || state == CSUM),
        .expired (timeoutHit)
    );
`else
    assign timeoutHit = 1'b0;
`endif

    assign rdNext = rdIdx + ONE;

    always_comb begin
        stateNext = state;
        errPulse  = 1'b0;
        okPulse   = 1'b0;
        errNext   = errCode_t'(errCode);
        case (state)
            HUNT: begin
                if (rxValid && rxData == SYNC_BYTE) stateNext = LEN;
            end
            LEN: begin
                if (rxValid) begin
                    if (rxData == 8'h00 || rxData > 8'(MAX_LEN)) begin
                        errPulse  = 1'b1;
                        errNext   = ERR_BADLEN;
                        stateNext = HUNT;
                    end else begin
                        stateNext = PAYLOAD;
                    end
                end else if (timeoutHit) begin
                    errPulse  = 1'b1;
                    errNext   = ERR_TIMEOUT;
                    stateNext = HUNT;
                end
            end
            PAYLOAD: begin
                if (rxValid) begin
                    if (idx + ONE == len) stateNext = CSUM;
                end else if (timeoutHit) begin
                    errPulse  = 1'b1;
                    errNext   = ERR_TIMEOUT;
                    stateNext = HUNT;
                end
            end
            CSUM: begin
                if (rxValid) begin
                    if (8'(sum + rxData) == 8'h00) begin
                        okPulse   = 1'b1;
                        stateNext = EMIT;
                    end else begin
                        errPulse  = 1'b1;
                        errNext   = ERR_CSUM;
                        stateNext = HUNT;
                    end
                end else if (timeoutHit) begin
                    errPulse  = 1'b1;
                    errNext   = ERR_TIMEOUT;
                    stateNext = HUNT;
                end
            end
            EMIT: begin
                if (rxValid) begin
                    errPulse = 1'b1;
                    errNext  = ERR_OVERRUN;
                end
                if (outValid && outReady && outLast) stateNext = HUNT;
            end
            default: stateNext = HUNT;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= HUNT;
            len      <= '0;
            idx      <= '0;
            rdIdx    <= '0;
            sum      <= '0;
            outData  <= '0;
            outValid <= 1'b0;
            outLast  <= 1'b0;
            frameOk  <= 1'b0;
            frameErr <= 1'b0;
            errCode  <= '0;
            busy     <= 1'b0;
        end else begin
            state    <= stateNext;
            busy     <= (stateNext != HUNT);
            frameOk  <= okPulse;
            frameErr <= errPulse;
            if (errPulse) errCode <= errNext;
            case (state)
                LEN: begin
                    if (rxValid) begin
                        len <= rxData[IW-1:0];
                        sum <= rxData;
                        idx <= '0;
                    end
                end
                PAYLOAD: begin
                    if (rxValid) begin
                        sum <= sum + rxData;
                        idx <= idx + ONE;
                    end
                end
                CSUM: begin
                    // First byte is presented alongside frameOk, so EMIT starts with data already valid.
                    if (okPulse) begin
                        rdIdx    <= '0;
                        outData  <= payloadBuf[0];
                        outValid <= 1'b1;
                        outLast  <= (len == ONE);
                    end
                end
                EMIT: begin
                    if (outValid && outReady) begin
                        if (outLast) begin
                            outValid <= 1'b0;
                            outLast  <= 1'b0;
                        end else begin
                            rdIdx   <= rdNext;
                            outData <= payloadBuf[rdNext[AW-1:0]];
                            outLast <= (rdNext == len - ONE);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state == PAYLOAD && rxValid) payloadBuf[idx[AW-1:0]] <= rxData;
    end

endmodule

// File: tb/tb_uart_frame_parser.sv
// Directed self-checking bench for uart_frame_parser; timeout case depends on UART_FRAME_TIMEOUT_EN.
module tb_uart_frame_parser;

    logic       clk;
    logic       reset;
    logic [7:0] rxData;
    logic       rxValid;
    logic [7:0] outData;
    logic       outValid;
    logic       outReady;
    logic       outLast;
    logic       frameOk;
    logic       frameErr;
    logic [1:0] errCode;
    logic       busy;

    uart_frame_parser #(
        .SYNC_BYTE      (8'hA5),
        .MAX_LEN        (16),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .rxData   (rxData),
        .rxValid  (rxValid),
        .outData  (outData),
        .outValid (outValid),
        .outReady (outReady),
        .outLast  (outLast),
        .frameOk  (frameOk),
        .frameErr (frameErr),
        .errCode  (errCode),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Event log filled by the negedge monitor
    int         okCnt = 0;
    int         errCnt = 0;
    int         cyc = 0;
    int         errCyc = 0;
    int         sentCyc = 0;
    logic [1:0] errLog [$];
    logic [7:0] outQ [$];
    logic       lastQ [$];
    int         hsCyc [$];
    logic       prevStall = 1'b0;
    logic       prevValid = 1'b0;
    logic [7:0] prevData = 8'h00;
    logic       prevLast = 1'b0;
    logic       bpOn = 1'b0;

    always @(negedge clk) begin
        if (!reset) begin
            if (prevStall) begin
                checkVal("holdValid", {31'd0, outValid}, 32'd1);
                checkVal("holdData", {24'd0, outData}, {24'd0, prevData});
                checkVal("holdLast", {31'd0, outLast}, {31'd0, prevLast});
            end
            if (outValid && !prevValid) checkVal("okWithValid", {31'd0, frameOk}, 32'd1);
            if (frameOk) okCnt++;
            if (frameErr) begin
                errCnt++;
                errLog.push_back(errCode);
                errCyc = cyc;
            end
            if (outValid && outReady) begin
                outQ.push_back(outData);
                lastQ.push_back(outLast);
                hsCyc.push_back(cyc);
            end
        end
        prevStall = outValid && !outReady && !reset;
        prevValid = outValid;
        prevData  = outData;
        prevLast  = outLast;
        cyc++;
    end

    function automatic logic [31:0] errAt(input int i);
        return (i < errLog.size()) ? {30'd0, errLog[i]} : 32'hFFFF;
    endfunction

    task automatic clearLogs();
        okCnt = 0;
        errCnt = 0;
        errLog.delete();
        outQ.delete();
        lastQ.delete();
        hsCyc.delete();
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic sendByte(input logic [7:0] b);
        @(posedge clk);
        #1;
        rxData  = b;
        rxValid = 1'b1;
        sentCyc = cyc;
        @(posedge clk);
        #1;
        rxValid = 1'b0;
    endtask

    task automatic sendValid(input logic [7:0] csum);
        sendByte(8'hA5);
        sendByte(8'h03);
        sendByte(8'h11);
        sendByte(8'h22);
        sendByte(8'h33);
        sendByte(csum);
    endtask

    task automatic waitIdle(input string tag);
        int n = 0;
        while ((busy || outValid) && n < 300) begin
            tick(1);
            n++;
        end
        checkVal(tag, {31'd0, busy | outValid}, 32'd0);
        tick(2);
    endtask

    task automatic checkFrame(input string tag);
        logic [7:0] expB [3] = '{8'h11, 8'h22, 8'h33};
        checkVal({tag, ".nBytes"}, outQ.size(), 32'd3);
        for (int i = 0; i < 3; i++) begin
            checkVal($sformatf("%s.byte%0d", tag, i),
                     (i < outQ.size()) ? {24'd0, outQ[i]} : 32'hFFFF, {24'd0, expB[i]});
            checkVal($sformatf("%s.last%0d", tag, i),
                     (i < lastQ.size()) ? {31'd0, lastQ[i]} : 32'hFFFF, (i == 2) ? 32'd1 : 32'd0);
        end
    endtask

    initial begin
        reset    = 1'b1;
        rxData   = 8'h00;
        rxValid  = 1'b0;
        outReady = 1'b1;
        tick(3);
        checkVal("rst.outData", {24'd0, outData}, 32'd0);
        checkVal("rst.outValid", {31'd0, outValid}, 32'd0);
        checkVal("rst.outLast", {31'd0, outLast}, 32'd0);
        checkVal("rst.frameOk", {31'd0, frameOk}, 32'd0);
        checkVal("rst.frameErr", {31'd0, frameErr}, 32'd0);
        checkVal("rst.errCode", {30'd0, errCode}, 32'd0);
        checkVal("rst.busy", {31'd0, busy}, 32'd0);
        reset = 1'b0;
        tick(2);

        // Valid frame, full-rate consumer
        clearLogs();
        sendValid(8'h97);
        waitIdle("valid.idle");
        checkVal("valid.okCnt", okCnt, 32'd1);
        checkVal("valid.errCnt", errCnt, 32'd0);
        checkFrame("valid");
        if (hsCyc.size() == 3) begin
            checkVal("valid.rate01", hsCyc[1] - hsCyc[0], 32'd1);
            checkVal("valid.rate12", hsCyc[2] - hsCyc[1], 32'd1);
        end
        checkVal("valid.busy", {31'd0, busy}, 32'd0);

        // Bad checksum
        clearLogs();
        sendValid(8'h98);
        waitIdle("csum.idle");
        checkVal("csum.errCnt", errCnt, 32'd1);
        checkVal("csum.code", errAt(0), 32'd0);
        checkVal("csum.okCnt", okCnt, 32'd0);
        checkVal("csum.nBytes", outQ.size(), 32'd0);

        // Zero and oversize length, then a good frame
        clearLogs();
        sendByte(8'hA5);
        sendByte(8'h00);
        sendByte(8'hA5);
        sendByte(8'h11);
        tick(2);
        checkVal("badlen.busy", {31'd0, busy}, 32'd0);
        sendValid(8'h97);
        waitIdle("badlen.idle");
        checkVal("badlen.errCnt", errCnt, 32'd2);
        checkVal("badlen.code0", errAt(0), 32'd1);
        checkVal("badlen.code1", errAt(1), 32'd1);
        checkVal("badlen.okCnt", okCnt, 32'd1);
        checkFrame("badlen");

        // Garbage then valid frame with outReady pattern 1-0-0-1
        clearLogs();
        bpOn = 1'b1;
        fork
            begin
                int k = 0;
                while (bpOn) begin
                    outReady = (k % 4 == 0) || (k % 4 == 3);
                    k++;
                    tick(1);
                end
            end
        join_none
        sendByte(8'h00);
        sendByte(8'hFF);
        sendByte(8'h5A);
        tick(1);
        checkVal("garbage.busy", {31'd0, busy}, 32'd0);
        sendValid(8'h97);
        waitIdle("bp.idle");
        bpOn = 1'b0;
        outReady = 1'b1;
        checkVal("bp.okCnt", okCnt, 32'd1);
        checkVal("bp.errCnt", errCnt, 32'd0);
        checkFrame("bp");

        // Byte arriving while EMIT is stalled
        clearLogs();
        outReady = 1'b0;
        sendValid(8'h97);
        tick(2);
        checkVal("ovr.stallValid", {31'd0, outValid}, 32'd1);
        sendByte(8'h55);
        tick(2);
        checkVal("ovr.errCnt", errCnt, 32'd1);
        checkVal("ovr.code", errAt(0), 32'd3);
        checkVal("ovr.data", {24'd0, outData}, 32'h11);
        outReady = 1'b1;
        waitIdle("ovr.idle");
        checkVal("ovr.okCnt", okCnt, 32'd1);
        checkFrame("ovr");

        // Stalled frame: A5 02 11 then silence
        clearLogs();
        sendByte(8'hA5);
        sendByte(8'h02);
        sendByte(8'h11);
`ifdef UART_FRAME_TIMEOUT_EN
        begin
            int n = 0;
            while (errCnt == 0 && n < 300) begin
                tick(1);
                n++;
            end
        end
        tick(1);
        checkVal("tmo.errCnt", errCnt, 32'd1);
        checkVal("tmo.code", errAt(0), 32'd2);
        checkVal("tmo.delay", errCyc - sentCyc, 32'd101);
        checkVal("tmo.busy", {31'd0, busy}, 32'd0);
`else
        tick(200);
        checkVal("stall.busy", {31'd0, busy}, 32'd1);
        checkVal("stall.errCnt", errCnt, 32'd0);
        reset = 1'b1;
        #1;
        checkVal("abort.busy", {31'd0, busy}, 32'd0);
        checkVal("abort.frameErr", {31'd0, frameErr}, 32'd0);
        tick(2);
        reset = 1'b0;
        tick(2);
        checkVal("abort.errCnt", errCnt, 32'd0);
`endif

        // Recovery after the stalled frame
        clearLogs();
        sendValid(8'h97);
        waitIdle("recover.idle");
        checkVal("recover.okCnt", okCnt, 32'd1);
        checkFrame("recover");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/uart_frame_parser.md
# uart_frame_parser

Downstream consumer of the UART receiver: takes its byte stream (data + single-cycle valid pulse), hunts for a sync byte, collects a length-prefixed payload into an internal buffer and checks an 8-bit checksum. Only verified payloads are released on a valid/ready byte stream. Corrupt, malformed or stalled frames are discarded and reported.

## Interface
- `SYNC_BYTE`, 8'hA5: frame start marker.
- `MAX_LEN`, 16: maximum payload bytes (1..255); sets buffer depth.
- `TIMEOUT_CYCLES`, 17360: inter-byte timeout in clocks (4 byte-times at 50 MHz / 115200).
- `clk` in 1: single clock.
- `reset` in 1: asynchronous, active-high; clears all state and outputs.
- `rxData` in 8: byte from the UART receiver, sampled only when `rxValid`=1.
- `rxValid` in 1: one-cycle pulse per received byte.
- `outData` out 8: payload byte.
- `outValid` out 1: `outData` valid.
- `outReady` in 1: consumer accepts the byte when `outValid && outReady`.
- `outLast` out 1: marks the final payload byte.
- `frameOk` out 1: one-cycle pulse when a frame passes its checksum.
- `frameErr` out 1: one-cycle pulse when a frame is discarded.
- `errCode` out 2: 0 CSUM, 1 BADLEN, 2 TIMEOUT, 3 OVERRUN; valid while `frameErr`=1, otherwise holds its last value.
- `busy` out 1: high in every state except HUNT.

## Operation
- Frame format: SYNC, LEN, LEN payload bytes, CSUM.
- A frame is valid when (LEN + Σpayload + CSUM) mod 256 == 0.
- States:
  - HUNT: ignore bytes ≠ SYNC_BYTE. SYNC_BYTE → LEN.
  - LEN: LEN==0 or LEN>MAX_LEN → `frameErr`/BADLEN, then HUNT. Otherwise store len, sum=LEN, idx=0, then PAYLOAD.
  - PAYLOAD: write buf[idx], sum+=byte, idx++. When idx reaches len → CSUM.
  - CSUM: sum+byte == 0 → `frameOk`, then EMIT. Otherwise → `frameErr`/CSUM, then HUNT.
  - EMIT: present buf[rdIdx]. `outLast` = (rdIdx == len-1). Each handshake advances rdIdx. Handshake with `outLast` → HUNT.
- Sum is 8 bits and wraps. idx and rdIdx are $clog2(MAX_LEN+1) bits.
- Any `rxValid` in EMIT: byte dropped, `frameErr`/OVERRUN pulsed, emission continues unaffected.
- A SYNC_BYTE value inside LEN/PAYLOAD/CSUM is ordinary data; no resync.
- Buffer contents are not reset and are don't-care outside EMIT.

## Timing
- Reset values:
  - all outputs 0 (`outData`=8'h00, `errCode`=0);
  - state HUNT, counters 0.
- All outputs are registered.
- `frameOk`, `frameErr`: asserted the cycle after the `rxValid` that caused them, for exactly 1 cycle.
- `outValid`: rises with `frameOk`, and the first byte is presented on that same cycle.
- EMIT throughput is one byte per cycle while `outReady`=1.
- `outData`/`outLast` are held stable while `outValid && !outReady`.
- After the last handshake, `outValid`=0 and `busy`=0 the next cycle.
- A byte arriving on that cycle is processed in HUNT.
- An asynchronous reset mid-frame or mid-EMIT aborts immediately: no `frameErr`, no further output.

## Configuration
- `UART_FRAME_TIMEOUT_EN` defined:
  - A counter runs in LEN/PAYLOAD/CSUM, cleared on each `rxValid` and on state entry.
  - On reaching TIMEOUT_CYCLES → `frameErr`/TIMEOUT, then HUNT.
  - Not active in HUNT or EMIT.
- Undefined: no counter is built, a stalled frame waits indefinitely, and errCode 2 is never produced.

## Structure
- Package `uart_frame_pkg`: state enum (HUNT, LEN, PAYLOAD, CSUM, EMIT), errCode enum, default SYNC_BYTE constant.
- Optional sub-module `uart_frame_timer`: loadable/clearable timeout counter, instantiated only under `UART_FRAME_TIMEOUT_EN`.
- Payload buffer is an inferred register array of MAX_LEN × 8.

## Test plan
- Valid frame: feed A5 03 11 22 33 97 with `outReady`=1.
  - `frameOk` pulses once.
  - Out 11, 22, 33 on consecutive cycles, `outLast` on 33.
  - `busy` low afterwards.
- Bad checksum: feed A5 03 11 22 33 98.
  - `frameErr` with `errCode`=0.
  - No `outValid`; back in HUNT.
- Bad length: feed A5 00, then A5 11 with MAX_LEN=16.
  - Two BADLEN errors.
  - A following valid frame is still accepted.
- Garbage and backpressure: feed 00 FF 5A, then the valid frame, with `outReady` toggling 1-0-0-1.
  - Garbage ignored.
  - Bytes held stable during stalls, order intact.
- Overrun: a byte arrives while EMIT is stalled.
  - OVERRUN error pulsed.
  - Emitted payload unchanged.
- Timeout (macro on, TIMEOUT_CYCLES=100): feed A5 02 11 then idle.
  - TIMEOUT error at cycle 100 after 11.
  - Macro off: `busy` stays high.
